// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration stream loader.
// The CHK state only exists when CONFIG_LOADER_CHECKSUM_EN is defined.
package config_loader_pkg;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;
`endif

    localparam logic [15:0] DEFAULT_MAGIC     = 16'hC0F1;
    localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'h0000_0000;

    localparam int SUB_BLOCK_MSB = 31;
    localparam int SUB_BLOCK_LSB = 16;
    localparam int TILE_MSB      = 15;
    localparam int TILE_LSB      = 0;

    function automatic logic [15:0] sub_block_id(input logic [31:0] addr);
        return addr[SUB_BLOCK_MSB:SUB_BLOCK_LSB];
    endfunction

    function automatic logic [15:0] tile_id(input logic [31:0] addr);
        return addr[TILE_MSB:TILE_LSB];
    endfunction

endpackage

// File: rtl/config_stream_loader.sv
// Parses framed (addr, data) pairs from a 32-bit valid/ready stream onto the config bus.
// Optional trailing XOR checksum word enabled by CONFIG_LOADER_CHECKSUM_EN.
module config_stream_loader
    import config_loader_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = DEFAULT_IDLE_ADDR,
    parameter logic [15:0] MAGIC     = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] pairs_written
);

    state_e      state_q;
    logic [15:0] n_q;
    logic [15:0] pairs_q;
    logic [31:0] addr_q;
    logic [31:0] cfg_addr_q;
    logic [31:0] cfg_data_q;
    logic        done_q;
    logic        error_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
`endif

    logic accept;
    logic last_pair;

    // Ready needs no state: the loader can always take a word outside reset.
    assign in_ready  = !reset;
    assign accept    = in_valid && in_ready;
    assign last_pair = (pairs_q + 16'd1) == n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HDR;
            n_q        <= '0;
            pairs_q    <= '0;
            addr_q     <= '0;
            cfg_addr_q <= IDLE_ADDR;
            cfg_data_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // NOTE: bus and done default back to idle every cycle; a write below overrides for one cycle only.
            cfg_addr_q <= IDLE_ADDR;
            cfg_data_q <= '0;
            done_q     <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_HDR: begin
                        if (in_data[31:16] == MAGIC) begin
                            error_q <= 1'b0;
                            pairs_q <= '0;
                            n_q     <= in_data[15:0];
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                            if (in_data[15:0] != 16'd0) begin
                                state_q <= ST_ADDR;
                            end else begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                                state_q <= ST_CHK;
`else
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        addr_q  <= in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ in_data;
`endif
                        state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        cfg_addr_q <= addr_q;
                        cfg_data_q <= in_data;
                        pairs_q    <= pairs_q + 16'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ in_data;
`endif
                        if (last_pair) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            state_q <= ST_CHK;
`else
                            state_q <= ST_HDR;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_ADDR;
                        end
                    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (in_data != csum_q) begin
                            error_q <= 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end
`endif
                    default: state_q <= ST_HDR;
                endcase
            end
        end
    end

    assign config_addr   = cfg_addr_q;
    assign config_data   = cfg_data_q;
    assign busy          = (state_q != ST_HDR);
    assign done          = done_q;
    assign error         = error_q;
    assign pairs_written = pairs_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader; builds with or without CONFIG_LOADER_CHECKSUM_EN.
module tb_config_stream_loader;
    import config_loader_pkg::*;

    localparam logic [31:0] IDLE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] pairs_written;

    config_stream_loader dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pairs_written (pairs_written)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus monitor: logs every write seen, flags adjacent writes and stray data on idle cycles.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt;
    bit          prev_write;
    bit          adjacent;
    bit          stray;

    always @(negedge clk) begin
        if (config_addr !== IDLE) begin
            wr_addr.push_back(config_addr);
            wr_data.push_back(config_data);
            if (prev_write) adjacent = 1'b1;
            prev_write = 1'b1;
        end else begin
            if (config_data !== 32'h0) stray = 1'b1;
            prev_write = 1'b0;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        adjacent = 1'b0;
        stray    = 1'b0;
    endtask

    logic [31:0] tb_csum;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Idle gap with a header-looking word on the bus that must not be sampled.
    task automatic gap_then_send(input logic [31:0] w, input int g);
        in_valid = 1'b0;
        in_data  = 32'hC0F1_0005;
        repeat (g) @(posedge clk);
        #1;
        send_word(w);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        tb_csum = 32'h0;
        send_word({16'hC0F1, n});
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] d);
        send_word(a);
        tb_csum = tb_csum ^ a;
        send_word(d);
        tb_csum = tb_csum ^ d;
    endtask

    task automatic end_frame();
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send_word(tb_csum);
`endif
    endtask

    task automatic check_log(input string tag, input logic [31:0] ea[], input logic [31:0] ed[]);
        check({tag, "_count"}, wr_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea[i]);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
        end
    endtask

    logic [31:0] ea3[] = '{32'h0001_0001, 32'h0002_0005, 32'h0003_FFFF};
    logic [31:0] ed3[] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    logic [31:0] ea2[] = '{32'h0005_0010, 32'h0006_0020};
    logic [31:0] ed2[] = '{32'hAAAA_5555, 32'h1234_5678};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        clear_log();
        #12;
        check("rst_ready", in_ready, 1'b0);
        check("rst_addr", config_addr, IDLE);
        check("rst_data", config_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_pairs", pairs_written, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1'b1);
        idle(1);

        // Single pair frame.
        clear_log();
        send_hdr(16'd1);
        check("t1_busy_hdr", busy, 1'b1);
        send_pair(32'h0004_0003, 32'h0000_0002);
        check("t1_addr", config_addr, 32'h0004_0003);
        check("t1_data", config_data, 32'h0000_0002);
        check("t1_subblk", sub_block_id(config_addr), 16'h0004);
        check("t1_pairs", pairs_written, 16'd1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        check("t1_done_early", done, 1'b0);
        check("t1_busy_chk", busy, 1'b1);
        end_frame();
        check("t1_csum_done", done, 1'b1);
        check("t1_csum_err", error, 1'b0);
`else
        check("t1_done", done, 1'b1);
        check("t1_busy", busy, 1'b0);
`endif
        idle(1);
        check("t1_addr_idle", config_addr, IDLE);
        check("t1_data_idle", config_data, 32'h0);
        check("t1_done_low", done, 1'b0);
        check("t1_done_cnt", done_cnt, 1);

        // Bad magic, then empty good frame.
        clear_log();
        send_word(32'hBEEF_0002);
        check("t2_error", error, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_done", done, 1'b0);
        idle(2);
        check("t2_no_writes", wr_addr.size(), 0);
        send_hdr(16'd0);
        check("t2_err_clr", error, 1'b0);
        end_frame();
        check("t2_done", done, 1'b1);
        check("t2_busy_end", busy, 1'b0);
        idle(1);
        check("t2_done_cnt", done_cnt, 1);

        // Three pairs streamed back to back.
        clear_log();
        send_hdr(16'd3);
        for (int i = 0; i < 3; i++) send_pair(ea3[i], ed3[i]);
        end_frame();
        idle(2);
        check_log("t3", ea3, ed3);
        check("t3_adjacent", adjacent, 1'b0);
        check("t3_stray", stray, 1'b0);
        check("t3_pairs", pairs_written, 16'd3);
        check("t3_done_cnt", done_cnt, 1);

        // Two pairs with random stalls between every word.
        clear_log();
        gap_then_send({16'hC0F1, 16'd2}, $urandom_range(0, 3));
        tb_csum = 32'h0;
        for (int i = 0; i < 2; i++) begin
            gap_then_send(ea2[i], $urandom_range(0, 3));
            tb_csum = tb_csum ^ ea2[i];
            gap_then_send(ed2[i], $urandom_range(0, 3));
            tb_csum = tb_csum ^ ed2[i];
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        gap_then_send(tb_csum, $urandom_range(0, 3));
`endif
        idle(4);
        check_log("t4", ea2, ed2);
        check("t4_stray", stray, 1'b0);
        check("t4_pairs", pairs_written, 16'd2);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_error", error, 1'b0);
        check("t4_busy", busy, 1'b0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // Checksum good, then checksum bad.
        clear_log();
        send_hdr(16'd1);
        send_pair(32'h0007_0001, 32'h0000_0005);
        send_word(32'h0007_0004);
        check("t5_done", done, 1'b1);
        check("t5_error", error, 1'b0);
        clear_log();
        send_hdr(16'd1);
        send_pair(32'h0007_0001, 32'h0000_0005);
        send_word(32'h0000_0000);
        check("t5_bad_done", done, 1'b1);
        check("t5_bad_error", error, 1'b1);
        idle(1);
        check("t5_bad_writes", wr_addr.size(), 1);
        check("t5_bad_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hX, 32'h0007_0001);
`endif

        // Reset after the addr word aborts the pair.
        clear_log();
        send_hdr(16'd1);
        send_word(32'h0009_0009);
        reset = 1'b1;
        #2;
        check("t6_ready_rst", in_ready, 1'b0);
        check("t6_busy_rst", busy, 1'b0);
        check("t6_addr_rst", config_addr, IDLE);
        in_valid = 1'b1;
        in_data  = 32'h0000_1234;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        idle(1);
        check("t6_no_writes", wr_addr.size(), 0);
        check("t6_error_rst", error, 1'b0);
        send_word(32'h0000_1234);
        check("t6_hdr_parse", error, 1'b1);
        check("t6_hdr_busy", busy, 1'b0);
        send_hdr(16'd1);
        send_pair(32'h000A_0002, 32'h0000_0077);
        end_frame();
        idle(1);
        check("t6_writes", wr_addr.size(), 1);
        check("t6_wr_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hX, 32'h000A_0002);
        check("t6_wr_data", wr_data.size() > 0 ? wr_data[0] : 32'hX, 32'h0000_0077);
        check("t6_error_clr", error, 1'b0);
        check("t6_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
